cartpole_episode_ctrl: RTL and testbench
========================================

Name: cartpole_episode_ctrl

Overview:
- Episode sequencer directly downstream of the CartPole single-step compute stage; it also feeds that stage.
- Loads an initial 128-bit state and presents each observation to the agent, then collects the action.
- Fires the compute stage once per step and consumes its next-state, reward, done and valid outputs.
- Accumulates episode return and length, applies the step-limit truncation, and reports a per-episode summary before reloading.

Parameters:
STA_WL, 128, state width (4 x IEEE-754 fp32: x, x_dot, theta, theta_dot, MSB first)
ACT_WL, 1, action width
RWD_WL, 1, per-step reward width (unsigned)
STEP_WL, 10, step/length counter width
MAX_STEPS, 500, truncation limit (must be < 2^STEP_WL)
RET_WL, 16, accumulated-return width (unsigned, saturating)
TIMEOUT, 64, max cycles to wait for compute valid

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_start  in  1  level; enables leaving IDLE
i_init_sta  in  STA_WL  initial state for next episode
i_init_valid  in  1  initial state available
o_init_ready  out  1  controller accepts i_init_sta
o_obs  out  STA_WL  current observation
o_obs_valid  out  1  observation valid
i_obs_ready  in  1  agent accepts observation
i_act  in  ACT_WL  agent action
i_act_valid  in  1  action valid
o_act_ready  out  1  controller accepts action
o_cmp_ena  out  1  one-cycle fire pulse to compute stage
o_cmp_sta  out  STA_WL  state to compute stage
o_cmp_act  out  ACT_WL  action to compute stage
i_cmp_sta  in  STA_WL  next state from compute
i_cmp_rwd  in  RWD_WL  step reward from compute
i_cmp_done  in  1  terminal flag from compute
i_cmp_valid  in  1  compute result valid (sampled only in WAIT_RES)
o_ep_valid  out  1  episode summary valid
i_ep_ready  in  1  summary accepted
o_ep_len  out  STEP_WL  steps in finished episode
o_ep_ret  out  RET_WL  summed reward
o_ep_trunc  out  1  episode ended by MAX_STEPS, not done
o_err  out  1  sticky compute-timeout flag

Behaviour:
- Reset (i_rst high at an edge):
  - State goes to IDLE.
  - All valid/ready/ena outputs go to 0; o_err=0.
  - o_obs, o_cmp_sta, o_cmp_act, o_ep_len, o_ep_ret, o_ep_trunc, step counter and return accumulator go to 0.
  - Reset mid-episode discards everything; no summary is emitted.
- FSM states: IDLE, LOAD, PRESENT, WAIT_ACT, STEP, WAIT_RES, REPORT, FAULT.
- IDLE: go to LOAD when i_start=1.
- LOAD: o_init_ready=1.
  - On i_init_valid&o_init_ready: state_reg<=i_init_sta, step<=0, ret<=0, then go to PRESENT.
- PRESENT: o_obs=state_reg, o_obs_valid=1.
  - On i_obs_ready: go to WAIT_ACT.
  - o_obs_valid stays asserted and o_obs stays stable until accepted.
- WAIT_ACT: o_act_ready=1.
  - On i_act_valid: latch o_cmp_act<=i_act and o_cmp_sta<=state_reg, then go to STEP.
- STEP: o_cmp_ena=1 for exactly this one cycle; go to WAIT_RES.
  - o_cmp_sta and o_cmp_act stay stable until the next STEP.
- WAIT_RES: wait for i_cmp_valid; a watchdog counts cycles spent in this state.
  - On i_cmp_valid:
    - state_reg<=i_cmp_sta.
    - step<=step+1.
    - ret<=min(ret+i_cmp_rwd, 2^RET_WL-1), saturating.
  - If i_cmp_done=1 or step+1==MAX_STEPS: go to REPORT with o_ep_len=step+1, o_ep_ret=new ret, o_ep_trunc=(!i_cmp_done).
  - Otherwise go to PRESENT.
  - Done and limit reached together: o_ep_trunc=0 (done has priority).
  - Watchdog reaching TIMEOUT with no valid: o_err<=1, go to FAULT. FAULT is left only by reset.
- REPORT: o_ep_valid=1 with the summary held stable.
  - On i_ep_ready: go to LOAD if i_start=1, else IDLE.
- Latency, best case (all handshakes ready):
  - LOAD->PRESENT: 1 cycle.
  - PRESENT->WAIT_ACT: 1 cycle.
  - WAIT_ACT->STEP: 1 cycle.
  - STEP->WAIT_RES: 1 cycle.
  - WAIT_RES: compute latency plus 1 cycle.
  - Minimum step period is 4 cycles plus compute latency.
- Ready signals are functions of FSM state only; no combinational path from any input valid to any output ready.
- i_cmp_valid outside WAIT_RES is ignored.
- Dropping i_start mid-episode takes effect only after REPORT.

Test Plan:
- Reset mid-WAIT_RES -> next cycle FSM in IDLE, o_cmp_ena=0, o_ep_valid=0, o_err=0; no summary emitted.
- Init i_init_sta={BDDA4B6F,BE7002B9,3E53E72E,3F5F1AFC}, action 1, compute model returns done=1 rwd=1 on step 3 -> o_ep_valid with len=3, ret=3, trunc=0; o_cmp_ena pulsed exactly 3 times, each 1 cycle wide.
- Compute model never asserts done, rwd=1 -> REPORT after step 500 with len=500, ret=500, trunc=1. Then i_start=1 and a new init loads; counters restart at 0.
- done=1 exactly on step 500 -> len=500, trunc=0.
- Agent holds i_obs_ready=0 for 10 cycles -> o_obs_valid held and o_obs unchanged. o_ep_valid with i_ep_ready=0 -> summary held stable.
- Compute model never asserts valid -> o_err=1 after 64 cycles in WAIT_RES; FSM stays in FAULT until i_rst. A spurious i_cmp_valid in PRESENT has no effect.

Source files
------------

// File: rtl/cartpole_episode_ctrl.sv
// ----------------------------------------------------------------------------
// cartpole_episode_ctrl
// Episode sequencer around the CartPole single-step compute stage. It loads an
// initial state, hands each observation to the agent, collects the action,
// fires the compute stage once per step and folds the step results into the
// episode return/length. It then reports a per-episode summary.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_start                            level, allows leaving IDLE / re-arming
//   i_init_sta/_valid, o_init_ready    initial-state load handshake
//   o_obs/_valid, i_obs_ready          observation to the agent
//   i_act/_valid, o_act_ready          action from the agent
//   o_cmp_ena/_sta/_act                fire pulse and operands to compute
//   i_cmp_sta/_rwd/_done/_valid        compute results
//   o_ep_valid/_len/_ret/_trunc        episode summary, i_ep_ready accepts it
//   o_err                              sticky compute-timeout flag
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module cartpole_episode_ctrl #(
    parameter int unsigned STA_WL    = 128,
    parameter int unsigned ACT_WL    = 1,
    parameter int unsigned RWD_WL    = 1,
    parameter int unsigned STEP_WL   = 10,
    parameter int unsigned MAX_STEPS = 500,
    parameter int unsigned RET_WL    = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [STA_WL-1:0]  i_init_sta,
    input  logic               i_init_valid,
    output logic               o_init_ready,
    output logic [STA_WL-1:0]  o_obs,
    output logic               o_obs_valid,
    input  logic               i_obs_ready,
    input  logic [ACT_WL-1:0]  i_act,
    input  logic               i_act_valid,
    output logic               o_act_ready,
    output logic               o_cmp_ena,
    output logic [STA_WL-1:0]  o_cmp_sta,
    output logic [ACT_WL-1:0]  o_cmp_act,
    input  logic [STA_WL-1:0]  i_cmp_sta,
    input  logic [RWD_WL-1:0]  i_cmp_rwd,
    input  logic               i_cmp_done,
    input  logic               i_cmp_valid,
    output logic               o_ep_valid,
    input  logic               i_ep_ready,
    output logic [STEP_WL-1:0] o_ep_len,
    output logic [RET_WL-1:0]  o_ep_ret,
    output logic               o_ep_trunc,
    output logic               o_err
);

    localparam int unsigned WD_WL = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PRESENT, S_WAIT_ACT, S_STEP, S_WAIT_RES, S_REPORT, S_FAULT
    } state_t;

    state_t             r_state;
    logic [STA_WL-1:0]  r_sta;
    logic [STEP_WL-1:0] r_step;
    logic [RET_WL-1:0]  r_ret;
    logic [WD_WL-1:0]   r_wdog;
    logic               r_init_ready;
    logic               r_obs_valid;
    logic               r_act_ready;
    logic               r_cmp_ena;
    logic [STA_WL-1:0]  r_cmp_sta;
    logic [ACT_WL-1:0]  r_cmp_act;
    logic               r_ep_valid;
    logic [STEP_WL-1:0] r_ep_len;
    logic [RET_WL-1:0]  r_ep_ret;
    logic               r_ep_trunc;
    logic               r_err;

    // Step/return/watchdog arithmetic for the result being consumed this cycle
    logic [STEP_WL-1:0] w_step_nxt;
    logic [RET_WL:0]    w_ret_sum;
    logic [RET_WL-1:0]  w_ret_nxt;
    logic               w_last;
    logic [WD_WL-1:0]   w_wdog_nxt;

    assign w_step_nxt = r_step + STEP_WL'(1);
    assign w_ret_sum  = {1'b0, r_ret} + (RET_WL + 1)'(i_cmp_rwd);
    assign w_ret_nxt  = w_ret_sum[RET_WL] ? '1 : w_ret_sum[RET_WL-1:0];
    assign w_last     = i_cmp_done | (w_step_nxt == STEP_WL'(MAX_STEPS));
    assign w_wdog_nxt = r_wdog + WD_WL'(1);

    // Episode FSM; every handshake output is set on the transition into the
    // state that owns it, so readies depend on state only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_sta        <= '0;
            r_step       <= '0;
            r_ret        <= '0;
            r_wdog       <= '0;
            r_init_ready <= 1'b0;
            r_obs_valid  <= 1'b0;
            r_act_ready  <= 1'b0;
            r_cmp_ena    <= 1'b0;
            r_cmp_sta    <= '0;
            r_cmp_act    <= '0;
            r_ep_valid   <= 1'b0;
            r_ep_len     <= '0;
            r_ep_ret     <= '0;
            r_ep_trunc   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_LOAD;
                        r_init_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (i_init_valid && r_init_ready) begin
                        r_sta        <= i_init_sta;
                        r_step       <= '0;
                        r_ret        <= '0;
                        r_init_ready <= 1'b0;
                        r_obs_valid  <= 1'b1;
                        r_state      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (i_obs_ready) begin
                        r_obs_valid <= 1'b0;
                        r_act_ready <= 1'b1;
                        r_state     <= S_WAIT_ACT;
                    end
                end
                S_WAIT_ACT: begin
                    if (i_act_valid) begin
                        r_cmp_act   <= i_act;
                        r_cmp_sta   <= r_sta;
                        r_act_ready <= 1'b0;
                        r_cmp_ena   <= 1'b1;
                        r_state     <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_cmp_ena <= 1'b0;
                    r_wdog    <= '0;
                    r_state   <= S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    if (i_cmp_valid) begin
                        r_sta  <= i_cmp_sta;
                        r_step <= w_step_nxt;
                        r_ret  <= w_ret_nxt;
                        if (w_last) begin
                            // done wins over truncation when both coincide
                            r_ep_len   <= w_step_nxt;
                            r_ep_ret   <= w_ret_nxt;
                            r_ep_trunc <= ~i_cmp_done;
                            r_ep_valid <= 1'b1;
                            r_state    <= S_REPORT;
                        end else begin
                            r_obs_valid <= 1'b1;
                            r_state     <= S_PRESENT;
                        end
                    end else begin
                        r_wdog <= w_wdog_nxt;
                        if (w_wdog_nxt == WD_WL'(TIMEOUT)) begin
                            r_err   <= 1'b1;
                            r_state <= S_FAULT;
                        end
                    end
                end
                S_REPORT: begin
                    if (i_ep_ready) begin
                        r_ep_valid <= 1'b0;
                        if (i_start) begin
                            r_init_ready <= 1'b1;
                            r_state      <= S_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_init_ready = r_init_ready;
    assign o_obs        = r_sta;
    assign o_obs_valid  = r_obs_valid;
    assign o_act_ready  = r_act_ready;
    assign o_cmp_ena    = r_cmp_ena;
    assign o_cmp_sta    = r_cmp_sta;
    assign o_cmp_act    = r_cmp_act;
    assign o_ep_valid   = r_ep_valid;
    assign o_ep_len     = r_ep_len;
    assign o_ep_ret     = r_ep_ret;
    assign o_ep_trunc   = r_ep_trunc;
    assign o_err        = r_err;

endmodule

// File: tb/tb_cartpole_episode_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cartpole_episode_ctrl
// Directed bench for the episode sequencer: reset, a short done-terminated
// episode with agent/summary backpressure, truncation at the step limit,
// done on the limit step, reset mid-step and the compute watchdog.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cartpole_episode_ctrl;

    logic          clk;
    logic          i_rst;
    logic          i_start;
    logic [127:0]  i_init_sta;
    logic          i_init_valid;
    logic          o_init_ready;
    logic [127:0]  o_obs;
    logic          o_obs_valid;
    logic          i_obs_ready;
    logic [0:0]    i_act;
    logic          i_act_valid;
    logic          o_act_ready;
    logic          o_cmp_ena;
    logic [127:0]  o_cmp_sta;
    logic [0:0]    o_cmp_act;
    logic [127:0]  i_cmp_sta;
    logic [0:0]    i_cmp_rwd;
    logic          i_cmp_done;
    logic          i_cmp_valid;
    logic          o_ep_valid;
    logic          i_ep_ready;
    logic [9:0]    o_ep_len;
    logic [15:0]   o_ep_ret;
    logic          o_ep_trunc;
    logic          o_err;

    cartpole_episode_ctrl dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_init_sta(i_init_sta), .i_init_valid(i_init_valid), .o_init_ready(o_init_ready),
        .o_obs(o_obs), .o_obs_valid(o_obs_valid), .i_obs_ready(i_obs_ready),
        .i_act(i_act), .i_act_valid(i_act_valid), .o_act_ready(o_act_ready),
        .o_cmp_ena(o_cmp_ena), .o_cmp_sta(o_cmp_sta), .o_cmp_act(o_cmp_act),
        .i_cmp_sta(i_cmp_sta), .i_cmp_rwd(i_cmp_rwd), .i_cmp_done(i_cmp_done),
        .i_cmp_valid(i_cmp_valid),
        .o_ep_valid(o_ep_valid), .i_ep_ready(i_ep_ready), .o_ep_len(o_ep_len),
        .o_ep_ret(o_ep_ret), .o_ep_trunc(o_ep_trunc), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_asrt = 0;
    int           n_fail = 0;
    int           ena_cnt = 0;
    int           ena_wide = 0;
    logic         ena_prev = 1'b0;
    logic [127:0] exp_sta;

    // Fire-pulse counter: counts high cycles and back-to-back highs
    always @(negedge clk) begin
        if (o_cmp_ena === 1'b1) begin
            ena_cnt++;
            if (ena_prev) ena_wide++;
        end
        ena_prev = (o_cmp_ena === 1'b1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_ep(input logic [127:0] init);
        for (int i = 0; i < 5 && o_init_ready !== 1'b1; i++) @(negedge clk);
        chk("init_ready", 128'(o_init_ready), 128'(1));
        i_init_sta   = init;
        i_init_valid = 1'b1;
        @(negedge clk);
        i_init_valid = 1'b0;
        exp_sta      = init;
    endtask

    // Handshake obs, send action 1, check the fire, return after 'lat' cycles
    task automatic run_step(input logic rwd, input logic done, input int lat);
        for (int i = 0; i < 5 && o_obs_valid !== 1'b1; i++) @(negedge clk);
        chk("obs_valid", 128'(o_obs_valid), 128'(1));
        chk("obs", o_obs, exp_sta);
        i_obs_ready = 1'b1;
        @(negedge clk);
        i_obs_ready = 1'b0;
        chk("act_ready", 128'(o_act_ready), 128'(1));
        i_act       = 1'b1;
        i_act_valid = 1'b1;
        @(negedge clk);
        i_act_valid = 1'b0;
        chk("cmp_ena", 128'(o_cmp_ena), 128'(1));
        chk("cmp_sta", o_cmp_sta, exp_sta);
        chk("cmp_act", 128'(o_cmp_act), 128'(1));
        @(negedge clk);
        repeat (lat) @(negedge clk);
        exp_sta     = exp_sta + 128'h1_0000_0003;
        i_cmp_sta   = exp_sta;
        i_cmp_rwd   = rwd;
        i_cmp_done  = done;
        i_cmp_valid = 1'b1;
        @(negedge clk);
        i_cmp_valid = 1'b0;
        i_cmp_done  = 1'b0;
    endtask

    task automatic chk_sum(input int len, input int ret, input logic trunc);
        chk("ep_valid", 128'(o_ep_valid), 128'(1));
        chk("ep_len", 128'(o_ep_len), 128'(len));
        chk("ep_ret", 128'(o_ep_ret), 128'(ret));
        chk("ep_trunc", 128'(o_ep_trunc), 128'(trunc));
    endtask

    int ena_base;
    int wide_base;

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_init_sta = '0; i_init_valid = 1'b0;
        i_obs_ready = 1'b0; i_act = '0; i_act_valid = 1'b0; i_cmp_sta = '0;
        i_cmp_rwd = '0; i_cmp_done = 1'b0; i_cmp_valid = 1'b0; i_ep_ready = 1'b0;
        exp_sta = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_init_ready", 128'(o_init_ready), 128'(0));
        chk("rst_obs_valid", 128'(o_obs_valid), 128'(0));
        chk("rst_cmp_ena", 128'(o_cmp_ena), 128'(0));
        chk("rst_ep_valid", 128'(o_ep_valid), 128'(0));
        chk("rst_err", 128'(o_err), 128'(0));
        chk("rst_obs", o_obs, 128'(0));
        chk("rst_ep_len", 128'(o_ep_len), 128'(0));
        i_rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", 128'(o_init_ready), 128'(0));

        // Episode A: done on step 3, with agent and summary backpressure
        i_start   = 1'b1;
        ena_base  = ena_cnt;
        wide_base = ena_wide;
        load_ep(128'hBDDA4B6F_BE7002B9_3E53E72E_3F5F1AFC);
        i_cmp_valid = 1'b1;
        i_cmp_done  = 1'b1;
        i_cmp_sta   = '1;
        for (int i = 0; i < 10; i++) begin
            chk("hold_obs_valid", 128'(o_obs_valid), 128'(1));
            chk("hold_obs", o_obs, exp_sta);
            @(negedge clk);
            i_cmp_valid = 1'b0;
            i_cmp_done  = 1'b0;
        end
        run_step(1'b1, 1'b0, 2);
        run_step(1'b1, 1'b0, 0);
        run_step(1'b1, 1'b1, 3);
        chk_sum(3, 3, 1'b0);
        chk("ena_pulses", 128'(ena_cnt - ena_base), 128'(3));
        chk("ena_width", 128'(ena_wide - wide_base), 128'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_sum(3, 3, 1'b0);
        end
        i_ep_ready = 1'b1;
        @(negedge clk);
        i_ep_ready = 1'b0;
        chk("ep_valid_drop", 128'(o_ep_valid), 128'(0));

        // Episode B: never done, truncated at the limit
        load_ep(128'h3F800000_00000000_3D000000_00000000);
        for (int s = 1; s <= 500; s++) run_step(1'b1, 1'b0, 0);
        chk_sum(500, 500, 1'b1);
        i_ep_ready = 1'b1;
        @(negedge clk);
        i_ep_ready = 1'b0;

        // Episode C: odd-step rewards, done coincides with the limit step
        load_ep(128'h00000000_3F000000_BD800000_3E000000);
        for (int s = 1; s <= 500; s++) run_step(1'((s % 2) == 1), (s == 500), 0);
        chk_sum(500, 250, 1'b0);
        i_start    = 1'b0;
        i_ep_ready = 1'b1;
        @(negedge clk);
        i_ep_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_report", 128'(o_init_ready), 128'(0));

        // Episode D: reset while waiting for the compute result
        i_start = 1'b1;
        load_ep(128'h11111111_22222222_33333333_44444444);
        i_obs_ready = 1'b1;
        @(negedge clk);
        i_obs_ready = 1'b0;
        i_act_valid = 1'b1;
        @(negedge clk);
        i_act_valid = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        i_rst   = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("mid_rst_cmp_ena", 128'(o_cmp_ena), 128'(0));
        chk("mid_rst_ep_valid", 128'(o_ep_valid), 128'(0));
        chk("mid_rst_err", 128'(o_err), 128'(0));
        chk("mid_rst_init_ready", 128'(o_init_ready), 128'(0));
        chk("mid_rst_ep_len", 128'(o_ep_len), 128'(0));
        i_cmp_valid = 1'b1;
        i_cmp_done  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_summary", 128'(o_ep_valid), 128'(0));
        end
        i_cmp_valid = 1'b0;
        i_cmp_done  = 1'b0;

        // Watchdog: compute never answers
        i_start = 1'b1;
        load_ep(128'h55555555_66666666_77777777_88888888);
        i_obs_ready = 1'b1;
        @(negedge clk);
        i_obs_ready = 1'b0;
        i_act_valid = 1'b1;
        @(negedge clk);
        i_act_valid = 1'b0;
        chk("wd_cmp_ena", 128'(o_cmp_ena), 128'(1));
        repeat (64) @(negedge clk);
        chk("wd_err_early", 128'(o_err), 128'(0));
        @(negedge clk);
        chk("wd_err_set", 128'(o_err), 128'(1));
        i_cmp_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("fault_err", 128'(o_err), 128'(1));
            chk("fault_init_ready", 128'(o_init_ready), 128'(0));
            chk("fault_obs_valid", 128'(o_obs_valid), 128'(0));
        end
        i_cmp_valid = 1'b0;
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("fault_rst_err", 128'(o_err), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
